// File: rtl/c7bexu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : c7bexu_pkg
// Description : Shared defaults, address-width derivation and flattened
//               port-slice helpers for the c7bexu register file/scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package c7bexu_pkg;

    localparam int DEF_DW      = 32;
    localparam int DEF_NREG    = 32;
    localparam int DEF_NRP     = 6;
    localparam int DEF_NWP     = 2;
    localparam int DEF_R0_ZERO = 1;

    // Address width for a power-of-two register count (at least one bit).
    function automatic int aw_of(input int nreg);
        return (nreg <= 2) ? 1 : $clog2(nreg);
    endfunction

    // Low bit of lane idx inside a flattened bus of w-bit lanes.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/c7bexu_sb.sv
`default_nettype none
// ============================================================================
// Module      : c7bexu_sb
// Description : Register scoreboard: one pending bit per register, set by
//               issue, cleared by write-back, bulk-cleared by flush, plus a
//               registered popcount of the pending bits.
// Revision    : 1.0 - initial release
// ============================================================================
module c7bexu_sb
    import c7bexu_pkg::*;
#(
    parameter  int NREG    = DEF_NREG,
    parameter  int NWP     = DEF_NWP,
    parameter  int R0_ZERO = DEF_R0_ZERO,
    localparam int AW      = aw_of(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWP-1:0]    wen,
    input  logic [NWP*AW-1:0] waddr,
    input  logic [NWP-1:0]    iss_en,
    input  logic [NWP*AW-1:0] iss_addr,
    input  logic              flush,
    output logic [NREG-1:0]   pending,
    output logic [AW:0]       busy_cnt
);

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic [AW:0]     cnt_q;
    logic [AW:0]     cnt_d;

    // Next pending set: retire first, then issue so a new producer wins; flush overrides all.
    always_comb begin
        pend_d = pend_q;
        for (int k = 0; k < NWP; k++) begin
            if (wen[k]) begin
                pend_d[waddr[slice_lo(k, AW) +: AW]] = 1'b0;
            end
        end
        for (int k = 0; k < NWP; k++) begin
            if (iss_en[k]) begin
                pend_d[iss_addr[slice_lo(k, AW) +: AW]] = 1'b1;
            end
        end
        if (flush) begin
            pend_d = '0;
        end
        if (R0_ZERO != 0) begin
            pend_d[0] = 1'b0;
        end
    end

    // Popcount of the next pending set so the count lands on the same edge as the bits.
    always_comb begin
        cnt_d = '0;
        for (int r = 0; r < NREG; r++) begin
            cnt_d = cnt_d + (AW + 1)'(pend_d[r]);
        end
    end

    // Scoreboard state with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending  = pend_q;
    assign busy_cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/c7bexu_rf_sb.sv
`default_nettype none
// ============================================================================
// Module      : c7bexu_rf_sb
// Description : Multi-port register file with same-cycle write bypass and an
//               attached pending-write scoreboard driving operand-ready flags.
// Revision    : 1.0 - initial release
// ============================================================================
module c7bexu_rf_sb
    import c7bexu_pkg::*;
#(
    parameter  int DW      = DEF_DW,
    parameter  int NREG    = DEF_NREG,
    parameter  int NRP     = DEF_NRP,
    parameter  int NWP     = DEF_NWP,
    parameter  int R0_ZERO = DEF_R0_ZERO,
    localparam int AW      = aw_of(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRP*AW-1:0] raddr,
    output logic [NRP*DW-1:0] rdata,
    output logic [NRP-1:0]    rrdy,
    input  logic [NWP-1:0]    wen,
    input  logic [NWP*AW-1:0] waddr,
    input  logic [NWP*DW-1:0] wdata,
    input  logic [NWP-1:0]    iss_en,
    input  logic [NWP*AW-1:0] iss_addr,
    input  logic              flush,
    output logic [AW:0]       busy_cnt
);

    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic [NREG-1:0] w_pending;

    c7bexu_sb #(
        .NREG    (NREG),
        .NWP     (NWP),
        .R0_ZERO (R0_ZERO)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .wen      (wen),
        .waddr    (waddr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .pending  (w_pending),
        .busy_cnt (busy_cnt)
    );

    // Commit write-backs in ascending port order so the highest colliding port lands last.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            regs_d[r] = regs_q[r];
        end
        for (int k = 0; k < NWP; k++) begin
            if (wen[k]) begin
                regs_d[waddr[slice_lo(k, AW) +: AW]] = wdata[slice_lo(k, DW) +: DW];
            end
        end
        if (R0_ZERO != 0) begin
            regs_d[0] = '0;
        end
    end

    // Register storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    // Combinational read with bypass from the highest matching write port; r0 is hardwired when enabled.
    always_comb begin
        logic [AW-1:0] v_addr;
        logic [DW-1:0] v_data;
        logic          v_hit;
        rdata  = '0;
        rrdy   = '0;
        v_addr = '0;
        v_data = '0;
        v_hit  = 1'b0;
        for (int i = 0; i < NRP; i++) begin
            v_addr = raddr[slice_lo(i, AW) +: AW];
            v_data = regs_q[v_addr];
            v_hit  = 1'b0;
            for (int k = 0; k < NWP; k++) begin
                if (wen[k] && (waddr[slice_lo(k, AW) +: AW] == v_addr)) begin
                    v_hit  = 1'b1;
                    v_data = wdata[slice_lo(k, DW) +: DW];
                end
            end
            rdata[slice_lo(i, DW) +: DW] = v_data;
            rrdy[i]                      = v_hit | ~w_pending[v_addr];
            if ((R0_ZERO != 0) && (v_addr == '0)) begin
                rdata[slice_lo(i, DW) +: DW] = '0;
                rrdy[i]                      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
